// File: rtl/scr1_cg_pkg.sv
// Shared types and limits for the clock gating controller and its channels.
package scr1_cg_pkg;

    typedef enum logic [1:0] {
        CG_ON   = 2'd0,
        CG_IDLE = 2'd1,
        CG_OFF  = 2'd2,
        CG_WAKE = 2'd3
    } cg_state_e;

    localparam int N_CH_MIN     = 1;
    localparam int N_CH_MAX     = 32;
    localparam int IDLE_CYC_MIN = 1;
    localparam int IDLE_CYC_MAX = 255;
    localparam int WAKE_CYC_MAX = 15;

    // Counter must hold both the idle reload and the wake reload.
    function automatic int cg_cnt_width(input int idle_cyc, input int wake_cyc);
        int top_val;
        top_val = (idle_cyc > wake_cyc + 1) ? idle_cyc : wake_cyc + 1;
        return $clog2(top_val + 1);
    endfunction

endpackage

// File: rtl/scr1_cg.sv
// Latch-based glitch-free clock gate; test_mode forces the clock through.
module scr1_cg (
    input  logic clk,
    input  logic clk_en,
    input  logic test_mode,
    output logic clk_out
);

    logic en_latch;

    // Transparent only while clk is low, so enable changes never chop a high phase.
    always_latch begin
        if (!clk) begin
            en_latch <= clk_en | test_mode;
        end
    end

    assign clk_out = clk & en_latch;

endmodule

// File: rtl/scr1_cg_chan.sv
// One gated channel: idle hysteresis / wake settle FSM driving a scr1_cg cell.
module scr1_cg_chan
    import scr1_cg_pkg::*;
#(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic test_mode,
    input  logic allow,
    input  logic act,
    output logic clk_out,
    output logic clk_rdy,
    output logic gated,
    output logic gated_next
);

    localparam int CNT_W = cg_cnt_width(IDLE_CYC, WAKE_CYC);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             en_reg, en_next;
    logic             rdy_reg, rdy_next;
    logic             gated_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CG_ON;
            cnt_reg   <= '0;
            en_reg    <= 1'b1;
            rdy_reg   <= 1'b1;
            gated_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            en_reg    <= en_next;
            rdy_reg   <= rdy_next;
            gated_reg <= gated_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CG_ON: begin
                if (allow && !act) begin
                    state_next = CG_IDLE;
                    cnt_next   = IDLE_LOAD;
                end
            end
            CG_IDLE: begin
                if (act || !allow) begin
                    state_next = CG_ON;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = CG_OFF;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            CG_OFF: begin
                if (act || !allow) begin
                    state_next = CG_WAKE;
                    cnt_next   = WAKE_LOAD;
                end
            end
            CG_WAKE: begin
                // Wake always runs to completion, even if act drops meanwhile.
                if (cnt_reg == '0) begin
                    state_next = CG_ON;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = CG_ON;
                cnt_next   = '0;
            end
        endcase
        // Outputs are registered copies of the next-state decode.
        en_next    = (state_next != CG_OFF);
        rdy_next   = (state_next == CG_ON) || (state_next == CG_IDLE);
        gated_next = (state_next == CG_OFF);
    end

    assign clk_rdy = rdy_reg;
    assign gated   = gated_reg;

    scr1_cg u_cg (
        .clk       (clk),
        .clk_en    (en_reg),
        .test_mode (test_mode),
        .clk_out   (clk_out)
    );

endmodule

// File: rtl/scr1_cg_ctrl.sv
// Multi-channel clock gating controller: one independent gating FSM per domain.
module scr1_cg_ctrl
    import scr1_cg_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            test_mode,
    input  logic            cfg_gate_en,
    input  logic [N_CH-1:0] cfg_force_on,
    input  logic [N_CH-1:0] ch_busy,
    input  logic [N_CH-1:0] ch_wake_req,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] ch_clk_rdy,
    output logic [N_CH-1:0] ch_gated,
    output logic            all_gated
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
        IDLE_CYC < IDLE_CYC_MIN || IDLE_CYC > IDLE_CYC_MAX ||
        WAKE_CYC < 0 || WAKE_CYC > WAKE_CYC_MAX) begin : g_bad_param
        $error("scr1_cg_ctrl: parameter out of range");
    end

    logic [N_CH-1:0] gated_next;
    logic            all_gated_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic allow;
        logic act;

        assign allow = cfg_gate_en & ~cfg_force_on[gi] & ~test_mode;
        assign act   = ch_busy[gi] | ch_wake_req[gi];

        scr1_cg_chan #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_CYC (WAKE_CYC)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .test_mode  (test_mode),
            .allow      (allow),
            .act        (act),
            .clk_out    (clk_out[gi]),
            .clk_rdy    (ch_clk_rdy[gi]),
            .gated      (ch_gated[gi]),
            .gated_next (gated_next[gi])
        );
    end

    // Reduce the next-state flags so all_gated lines up with ch_gated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_gated_reg <= 1'b0;
        end else begin
            all_gated_reg <= &gated_next;
        end
    end

    assign all_gated = all_gated_reg;

endmodule

// File: tb/tb_scr1_cg_ctrl.sv
// Directed bench for scr1_cg_ctrl (N_CH=4, IDLE_CYC=16, WAKE_CYC=2).
module tb_scr1_cg_ctrl;

    localparam int N_CH     = 4;
    localparam int IDLE_CYC = 16;
    localparam int WAKE_CYC = 2;

    logic            clk;
    logic            rst;
    logic            test_mode;
    logic            cfg_gate_en;
    logic [N_CH-1:0] cfg_force_on;
    logic [N_CH-1:0] ch_busy;
    logic [N_CH-1:0] ch_wake_req;
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] ch_clk_rdy;
    logic [N_CH-1:0] ch_gated;
    logic            all_gated;

    int n_cmp  = 0;
    int n_fail = 0;

    scr1_cg_ctrl #(
        .N_CH     (N_CH),
        .IDLE_CYC (IDLE_CYC),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .test_mode    (test_mode),
        .cfg_gate_en  (cfg_gate_en),
        .cfg_force_on (cfg_force_on),
        .ch_busy      (ch_busy),
        .ch_wake_req  (ch_wake_req),
        .clk_out      (clk_out),
        .ch_clk_rdy   (ch_clk_rdy),
        .ch_gated     (ch_gated),
        .all_gated    (all_gated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("t=%0t check %s observed=%0h expected=%0h", $time, tag, obs, exp);
    endtask

    // Advance to 1ns after the next rising edge (inside the high phase).
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        test_mode    = 1'b0;
        cfg_gate_en  = 1'b1;
        cfg_force_on = '0;
        ch_busy      = '0;
        ch_wake_req  = '0;

        // Reset state
        tick(3);
        check("rst_rdy",       ch_clk_rdy, 4'hF);
        check("rst_gated",     ch_gated,   4'h0);
        check("rst_all_gated", all_gated,  1'b0);
        check("rst_clk_out",   clk_out,    4'hF);

        // Idle from reset release: idle first seen at edge 1, gate at edge 17
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= IDLE_CYC; e++) begin
            tick(1);
            check("idle_not_gated", ch_gated, 4'h0);
            check("idle_clk_runs",  clk_out,  4'hF);
        end
        tick(1);
        check("gate_edge_gated",   ch_gated,   4'hF);
        check("gate_edge_all",     all_gated,  1'b1);
        check("gate_edge_rdy",     ch_clk_rdy, 4'h0);
        check("gate_last_pulse",   clk_out,    4'hF);
        tick(1);
        check("gated_clk_stopped", clk_out,    4'h0);

        // Wake channel 0 with a one-cycle request at edge k
        ch_wake_req = 4'b0001;
        tick(1);
        ch_wake_req = 4'b0000;
        check("wake_k_gated",   ch_gated,   4'b1110);
        check("wake_k_all",     all_gated,  1'b0);
        check("wake_k_clk",     clk_out,    4'b0000);
        check("wake_k_rdy",     ch_clk_rdy, 4'b0000);
        tick(1);
        check("wake_k1_clk",    clk_out,    4'b0001);
        check("wake_k1_gated",  ch_gated,   4'b1110);
        check("wake_k1_rdy",    ch_clk_rdy, 4'b0000);
        tick(1);
        check("wake_k2_rdy",    ch_clk_rdy, 4'b0000);
        tick(1);
        check("wake_k3_rdy",    ch_clk_rdy, 4'b0001);

        // Busy holds everything on; a 10-cycle gap never reaches the gate
        ch_busy = 4'hF;
        tick(4);
        check("busy_rdy",   ch_clk_rdy, 4'hF);
        check("busy_gated", ch_gated,   4'h0);
        ch_busy = 4'h0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 9) ch_busy = 4'hF;
            check("gap_not_gated", ch_gated, 4'h0);
            check("gap_clk_runs",  clk_out,  4'hF);
        end
        check("gap_rdy", ch_clk_rdy, 4'hF);

        // Force-on keeps channel 2 running while the rest gate
        cfg_force_on = 4'b0100;
        ch_busy      = 4'h0;
        tick(20);
        check("force_gated", ch_gated,   4'b1011);
        check("force_all",   all_gated,  1'b0);
        check("force_rdy",   ch_clk_rdy, 4'b0100);
        check("force_clk",   clk_out,    4'b0100);

        // Release force; all gate, then test_mode reopens everything
        cfg_force_on = 4'b0000;
        tick(20);
        check("allgate_all", all_gated, 1'b1);
        check("allgate_clk", clk_out,   4'h0);
        test_mode = 1'b1;
        tick(1);
        check("tm_k_clk",    clk_out,    4'hF);
        check("tm_k_gated",  ch_gated,   4'h0);
        check("tm_k_rdy",    ch_clk_rdy, 4'h0);
        tick(2);
        check("tm_k2_rdy",   ch_clk_rdy, 4'h0);
        tick(1);
        check("tm_k3_rdy",   ch_clk_rdy, 4'hF);
        test_mode = 1'b0;

        // Reset during OFF: outputs flip at once, clock only resumes next low phase
        tick(20);
        check("off_again_all", all_gated, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_off_no_glitch", clk_out,    4'h0);
        check("rst_off_rdy",       ch_clk_rdy, 4'hF);
        check("rst_off_gated",     ch_gated,   4'h0);
        check("rst_off_all",       all_gated,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("rst_off_clk_back", clk_out, 4'hF);

        // Reset during WAKE with cnt=1
        tick(19);
        check("pre_wake_all", all_gated, 1'b1);
        ch_wake_req = 4'hF;
        tick(1);
        ch_wake_req = 4'h0;
        tick(1);
        check("wake_cnt1_rdy", ch_clk_rdy, 4'h0);
        rst = 1'b1;
        #1;
        check("rst_wake_rdy",   ch_clk_rdy, 4'hF);
        check("rst_wake_gated", ch_gated,   4'h0);
        check("rst_wake_clk",   clk_out,    4'hF);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("rst_wake_clk_next", clk_out,    4'hF);
        check("rst_wake_rdy_next", ch_clk_rdy, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
